// File: rtl/ptw_pkg.sv
// ptw_pkg: shared constants, PTE field offsets and FSM state type for the Sv39 page-table walker
package ptw_pkg;
  localparam int PPN_W    = 44;
  localparam int VPN_W    = 27;
  localparam int PADDR_W  = 56;
  localparam int LEVELS   = 3;
  localparam int PPN_LSB  = 10;
  localparam int PPN_MSB  = 53;
  localparam int RSVD_LSB = 54;
  localparam int F_V = 0;
  localparam int F_R = 1;
  localparam int F_W = 2;
  localparam int F_X = 3;
  localparam int F_U = 4;
  localparam int F_G = 5;
  localparam int F_A = 6;
  localparam int F_D = 7;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
endpackage

// File: rtl/ptw_pte_decode.sv
// ptw_pte_decode: combinational Sv39 PTE field extraction and validity/leaf/alignment classification
//   data       : raw 64-bit PTE
//   level      : level the PTE was fetched at (2 = root)
//   ppn, flags : PTE ppn field and d a g u x w r v flags
//   leaf       : PTE maps a page (v & (r | x))
//   invalid    : !v, write-only, or reserved bits set
//   misaligned : superpage leaf whose low ppn bits are not zero
module ptw_pte_decode
  import ptw_pkg::*;
(
  input  logic [63:0]      data,
  input  logic [1:0]       level,
  output logic [PPN_W-1:0] ppn,
  output logic [7:0]       flags,
  output logic             leaf,
  output logic             invalid,
  output logic             misaligned
);
  assign ppn        = data[PPN_MSB:PPN_LSB];
  assign flags      = data[7:0];
  assign leaf       = flags[F_V] & (flags[F_R] | flags[F_X]);
  assign invalid    = !flags[F_V] | (flags[F_W] & !flags[F_R]) | (|data[63:RSVD_LSB]);
  assign misaligned = leaf & (((level == 2'd2) & (|ppn[17:0])) | ((level == 2'd1) & (|ppn[8:0])));
endmodule

// File: rtl/ptw_sv39_walker.sv
// ptw_sv39_walker: Sv39 page-table walker issuing up to three PTE reads and returning leaf fields or a page fault
//   clock, reset (sync, active-low)
//   io_req_*      : translation request (vpn, satp root ppn sampled on accept)
//   io_mem_req_*  : PTE read request, held stable until accepted
//   io_mem_resp_* : PTE data pulse, only honoured while waiting for a read
//   io_resp_*     : registered walk result (ppn, flags, level, pf)
//   io_busy       : walk in progress
// Build option: define PTW_AD_CHECK_EN to fault on leaves with the A bit clear.
module ptw_sv39_walker
  import ptw_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [VPN_W-1:0]   io_req_vpn,
  input  logic [PPN_W-1:0]   io_satp_ppn,
  output logic               io_mem_req_valid,
  input  logic               io_mem_req_ready,
  output logic [PADDR_W-1:0] io_mem_req_addr,
  input  logic               io_mem_resp_valid,
  input  logic [63:0]        io_mem_resp_data,
  output logic               io_resp_valid,
  input  logic               io_resp_ready,
  output logic [PPN_W-1:0]   io_resp_ppn,
  output logic               io_resp_d,
  output logic               io_resp_a,
  output logic               io_resp_g,
  output logic               io_resp_u,
  output logic               io_resp_x,
  output logic               io_resp_w,
  output logic               io_resp_r,
  output logic               io_resp_v,
  output logic [1:0]         io_resp_level,
  output logic               io_resp_pf,
  output logic               io_busy
);
  state_e           state;
  logic [VPN_W-1:0] vpn;
  logic [PPN_W-1:0] cur_ppn;
  logic [1:0]       level;
  logic             g_acc;
  logic [PPN_W-1:0] resp_ppn;
  logic [7:0]       resp_flags;
  logic [1:0]       resp_level;
  logic             resp_pf;
  logic [PPN_W-1:0] pte_ppn;
  logic [7:0]       pte_flags;
  logic             pte_leaf;
  logic             pte_invalid;
  logic             pte_misaligned;
  logic             ad_fault;
  logic             fault;
  logic             descend;
  logic [8:0]       vpn_idx;
  logic [PPN_W-1:0] leaf_ppn;

  ptw_pte_decode u_dec (
    .data       (io_mem_resp_data),
    .level      (level),
    .ppn        (pte_ppn),
    .flags      (pte_flags),
    .leaf       (pte_leaf),
    .invalid    (pte_invalid),
    .misaligned (pte_misaligned)
  );

`ifdef PTW_AD_CHECK_EN
  assign ad_fault = pte_leaf & !pte_flags[F_A];
`else
  assign ad_fault = 1'b0;
`endif

  assign vpn_idx  = level == 2'd2 ? vpn[26:18] : level == 2'd1 ? vpn[17:9] : vpn[8:0];
  assign descend  = !pte_invalid & !pte_leaf & (level != 2'd0);
  // a valid pointer PTE at level 0 has nowhere left to go
  assign fault    = pte_invalid | (!pte_leaf & (level == 2'd0)) | pte_misaligned | ad_fault;
  // superpages take their untranslated low ppn bits from the vpn
  assign leaf_ppn = level == 2'd2 ? {pte_ppn[43:18], vpn[17:0]} :
                    level == 2'd1 ? {pte_ppn[43:9], vpn[8:0]} : pte_ppn;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      vpn        <= '0;
      cur_ppn    <= '0;
      level      <= '0;
      g_acc      <= 1'b0;
      resp_ppn   <= '0;
      resp_flags <= '0;
      resp_level <= '0;
      resp_pf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (io_req_valid) begin
          state   <= REQ;
          vpn     <= io_req_vpn;
          cur_ppn <= io_satp_ppn;
          level   <= 2'd2;
          g_acc   <= 1'b0;
        end
        REQ: if (io_mem_req_ready) state <= WAIT;
        WAIT: if (io_mem_resp_valid) begin
          if (descend) begin
            state   <= REQ;
            cur_ppn <= pte_ppn;
            level   <= level - 2'd1;
            g_acc   <= g_acc | pte_flags[F_G];
          end else begin
            state      <= RESP;
            resp_pf    <= fault;
            resp_level <= level;
            resp_ppn   <= fault ? '0 : leaf_ppn;
            resp_flags <= fault ? '0 : (pte_flags | {2'b00, g_acc, 5'b0});
          end
        end
        RESP: if (io_resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io_req_ready     = state == IDLE;
  assign io_busy          = state != IDLE;
  assign io_mem_req_valid = state == REQ;
  assign io_mem_req_addr  = PADDR_W'({cur_ppn, vpn_idx, 3'b000});
  assign io_resp_valid    = state == RESP;
  assign io_resp_ppn      = resp_ppn;
  assign io_resp_level    = resp_level;
  assign io_resp_pf       = resp_pf;
  assign io_resp_d        = resp_flags[F_D];
  assign io_resp_a        = resp_flags[F_A];
  assign io_resp_g        = resp_flags[F_G];
  assign io_resp_u        = resp_flags[F_U];
  assign io_resp_x        = resp_flags[F_X];
  assign io_resp_w        = resp_flags[F_W];
  assign io_resp_r        = resp_flags[F_R];
  assign io_resp_v        = resp_flags[F_V];
endmodule

// File: tb/tb_ptw_sv39_walker.sv
// tb_ptw_sv39_walker: table-driven directed walks plus backpressure and mid-walk reset sequences
module tb_ptw_sv39_walker;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [26:0] io_req_vpn = '0;
  logic [43:0] io_satp_ppn = '0;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready = 1'b1;
  logic [55:0] io_mem_req_addr;
  logic        io_mem_resp_valid = 1'b0;
  logic [63:0] io_mem_resp_data = '0;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic [43:0] io_resp_ppn;
  logic        io_resp_d, io_resp_a, io_resp_g, io_resp_u;
  logic        io_resp_x, io_resp_w, io_resp_r, io_resp_v;
  logic [1:0]  io_resp_level;
  logic        io_resp_pf;
  logic        io_busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ptw_sv39_walker dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_vpn(io_req_vpn), .io_satp_ppn(io_satp_ppn),
    .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
    .io_mem_req_addr(io_mem_req_addr),
    .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_data(io_mem_resp_data),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_ppn(io_resp_ppn),
    .io_resp_d(io_resp_d), .io_resp_a(io_resp_a), .io_resp_g(io_resp_g), .io_resp_u(io_resp_u),
    .io_resp_x(io_resp_x), .io_resp_w(io_resp_w), .io_resp_r(io_resp_r), .io_resp_v(io_resp_v),
    .io_resp_level(io_resp_level), .io_resp_pf(io_resp_pf), .io_busy(io_busy)
  );

  typedef struct {
    logic [26:0]      vpn;
    logic [43:0]      satp;
    int               n;
    logic [2:0][63:0] data;
    logic [2:0][55:0] addr;
    logic [43:0]      ppn;
    logic [7:0]       flags;
    logic [1:0]       lvl;
    logic             pf;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] resp_flags();
    return {io_resp_d, io_resp_a, io_resp_g, io_resp_u, io_resp_x, io_resp_w, io_resp_r, io_resp_v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input string name, input int which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if ((which == 0 && io_mem_req_valid) || (which == 1 && io_resp_valid)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    check({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_walk(input vec_t v, input int mem_stall, input int resp_stall, input bit req_on_done);
    bit ok;
    @(negedge clock);
    check("req_ready idle", io_req_ready, 1'b1);
    io_req_valid = 1'b1;
    io_req_vpn   = v.vpn;
    io_satp_ppn  = v.satp;
    @(negedge clock);
    io_req_valid = 1'b0;
    io_req_vpn   = '0;
    io_satp_ppn  = '0;
    for (int i = 0; i < v.n; i++) begin
      if (i == 0 && mem_stall > 0) io_mem_req_ready = 1'b0;
      wait_for("mem_req", 0, ok);
      if (!ok) return;
      for (int k = 0; k < mem_stall && i == 0; k++) begin
        check("stall mem_req_valid", io_mem_req_valid, 1'b1);
        check("stall addr", io_mem_req_addr, v.addr[0]);
        @(negedge clock);
      end
      check($sformatf("addr%0d", i), io_mem_req_addr, v.addr[i]);
      io_mem_req_ready = 1'b1;
      @(negedge clock);
      check("mem_req dropped", io_mem_req_valid, 1'b0);
      io_mem_resp_valid = 1'b1;
      io_mem_resp_data  = v.data[i];
      @(negedge clock);
      io_mem_resp_valid = 1'b0;
      io_mem_resp_data  = '0;
    end
    wait_for("resp", 1, ok);
    if (!ok) return;
    for (int k = 0; k <= resp_stall; k++) begin
      check("resp_valid", io_resp_valid, 1'b1);
      check("req_ready busy", io_req_ready, 1'b0);
      check("resp_ppn", io_resp_ppn, v.ppn);
      check("resp_flags", resp_flags(), v.flags);
      check("resp_level", io_resp_level, v.lvl);
      check("resp_pf", io_resp_pf, v.pf);
      if (k < resp_stall) @(negedge clock);
    end
    io_resp_ready = 1'b1;
    io_req_valid  = req_on_done;
    @(negedge clock);
    io_resp_ready = 1'b0;
    check("idle after resp", io_busy, 1'b0);
    check("req_ready after resp", io_req_ready, 1'b1);
    check("no mem_req after resp", io_mem_req_valid, 1'b0);
    io_req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    vecs[0] = '{27'h1, 44'h80000, 3, {64'h48D14CF, 64'h20000801, 64'h20000401},
                {56'h80002008, 56'h80001000, 56'h80000000}, 44'h12345, 8'hCF, 2'd0, 1'b0};
    vecs[1] = '{27'h1, 44'h80000, 1, {64'h0, 64'h0, 64'h0},
                {56'h0, 56'h0, 56'h80000000}, 44'h0, 8'h00, 2'd2, 1'b1};
    vecs[2] = '{27'h1, 44'h80000, 2, {64'h0, 64'h200800CF, 64'h20000401},
                {56'h0, 56'h80001000, 56'h80000000}, 44'h80201, 8'hCF, 2'd1, 1'b0};
    vecs[3] = '{27'h1, 44'h80000, 2, {64'h0, 64'h200804CF, 64'h20000401},
                {56'h0, 56'h80001000, 56'h80000000}, 44'h0, 8'h00, 2'd1, 1'b1};
`ifdef PTW_AD_CHECK_EN
    vecs[4] = '{27'h1, 44'h80000, 3, {64'h48D140F, 64'h20000801, 64'h20000401},
                {56'h80002008, 56'h80001000, 56'h80000000}, 44'h0, 8'h00, 2'd0, 1'b1};
`else
    vecs[4] = '{27'h1, 44'h80000, 3, {64'h48D140F, 64'h20000801, 64'h20000401},
                {56'h80002008, 56'h80001000, 56'h80000000}, 44'h12345, 8'h0F, 2'd0, 1'b0};
`endif
    vecs[5] = '{27'h1, 44'h80000, 3, {64'h48D14CF, 64'h20000801, 64'h20000421},
                {56'h80002008, 56'h80001000, 56'h80000000}, 44'h12345, 8'hEF, 2'd0, 1'b0};
    vecs[6] = '{27'h7FFFFFF, 44'h80000, 1, {64'h0, 64'h0, 64'h100000CF},
                {56'h0, 56'h0, 56'h80000FF8}, 44'h7FFFF, 8'hCF, 2'd2, 1'b0};
    vecs[7] = '{27'h1, 44'h80000, 3, {64'h20000C01, 64'h20000801, 64'h20000401},
                {56'h80002008, 56'h80001000, 56'h80000000}, 44'h0, 8'h00, 2'd0, 1'b1};
    vecs[8] = '{27'h1, 44'h80000, 1, {64'h0, 64'h0, 64'h20000405},
                {56'h0, 56'h0, 56'h80000000}, 44'h0, 8'h00, 2'd2, 1'b1};
    vecs[9] = '{27'h1, 44'h80000, 1, {64'h0, 64'h0, 64'h00400000200004CF},
                {56'h0, 56'h0, 56'h80000000}, 44'h0, 8'h00, 2'd2, 1'b1};

    repeat (3) @(negedge clock);
    check("reset req_ready", io_req_ready, 1'b1);
    check("reset busy", io_busy, 1'b0);
    check("reset mem_req_valid", io_mem_req_valid, 1'b0);
    check("reset resp_valid", io_resp_valid, 1'b0);
    check("reset resp_ppn", io_resp_ppn, 44'h0);
    check("reset resp_pf", io_resp_pf, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_walk(vecs[i], 0, 0, 1'b0);

    run_walk(vecs[0], 3, 5, 1'b1);
    check("simul req not taken", io_mem_req_valid, 1'b0);

    @(negedge clock);
    io_req_valid = 1'b1;
    io_req_vpn   = 27'h1;
    io_satp_ppn  = 44'h80000;
    @(negedge clock);
    io_req_valid = 1'b0;
    wait_for("rst mem_req", 0, ok);
    @(negedge clock);
    check("rst in wait busy", io_busy, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("post-reset busy", io_busy, 1'b0);
    check("post-reset mem_req_valid", io_mem_req_valid, 1'b0);
    check("post-reset req_ready", io_req_ready, 1'b1);
    io_mem_resp_valid = 1'b1;
    io_mem_resp_data  = 64'h48D14CF;
    @(negedge clock);
    io_mem_resp_valid = 1'b0;
    io_mem_resp_data  = '0;
    @(negedge clock);
    check("stale resp_valid", io_resp_valid, 1'b0);
    check("stale busy", io_busy, 1'b0);
    check("stale resp_ppn", io_resp_ppn, 44'h0);
    run_walk(vecs[0], 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ptw_sv39_walker.md
Name: ptw_sv39_walker

Overview:
- Sv39 page-table walker sitting directly upstream of the PTE optimization-barrier stage.
- Accepts a VPN translation request and issues up to three PTE reads to the memory port.
- Decodes each returned 64-bit PTE and produces the final leaf fields (ppn, d, a, g, u, x, w, r, v), which feed the barrier and then the TLB refill, or a page-fault indication.

Parameters:
- PPN_W, 44, physical page number width
- VPN_W, 27, virtual page number width (3 x 9-bit indices)
- PADDR_W, 56, physical address width of memory requests
- LEVELS, 3, page-table depth; fixed at 3 for Sv39

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low reset
- io_req_valid  in  1  translation request valid
- io_req_ready  out  1  walker idle, can accept a request
- io_req_vpn  in  VPN_W  VPN to translate
- io_satp_ppn  in  PPN_W  root table PPN, sampled at request accept
- io_mem_req_valid  out  1  PTE read request valid
- io_mem_req_ready  in  1  memory accepts request
- io_mem_req_addr  out  PADDR_W  PTE physical address
- io_mem_resp_valid  in  1  PTE data valid (single-cycle pulse)
- io_mem_resp_data  in  64  raw PTE
- io_resp_valid  out  1  walk result valid
- io_resp_ready  in  1  consumer accepts result
- io_resp_ppn  out  PPN_W  final PPN (superpage low bits filled from VPN)
- io_resp_d/a/g/u/x/w/r/v  out  1 each  leaf PTE flags; g is the OR of g over all visited levels
- io_resp_level  out  2  level the walk ended at (2 = root)
- io_resp_pf  out  1  page fault
- io_busy  out  1  walk in progress (state != IDLE)

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - REQ: mem_req_valid=1.
  - WAIT: waiting for mem_resp.
  - RESP: resp_valid=1.
- Transitions:
  - IDLE -> REQ on req handshake; capture vpn, satp_ppn; level := 2; g_acc := 0.
  - REQ -> WAIT on mem_req handshake.
  - WAIT -> (REQ, level-1) on a valid non-leaf PTE with level > 0.
  - WAIT -> RESP otherwise.
  - RESP -> IDLE on resp handshake.
- Address: {cur_ppn, vpn_idx[level], 3'b000}, zero-extended to PADDR_W. vpn_idx[2] = vpn[26:18], [1] = vpn[17:9], [0] = vpn[8:0].
  - cur_ppn starts at satp_ppn and becomes the PTE ppn at each non-leaf step.
- PTE decode:
  - ppn = data[53:10]; flags = data[7:0] (d a g u x w r v, MSB to LSB).
  - reserved = data[63:54] != 0.
  - invalid = !v | (w & !r) | reserved.
  - leaf = v & (r | x).
- Page fault (pf=1) when any of:
  - invalid;
  - non-leaf at level 0;
  - leaf at level 2 with ppn[17:0] != 0;
  - leaf at level 1 with ppn[8:0] != 0.
- On pf: resp_ppn = 0, flags = 0, level = level of the faulting PTE.
- Superpage result ppn:
  - level 2: {ppn[43:18], vpn[17:0]};
  - level 1: {ppn[43:9], vpn[8:0]}.
- Output timing:
  - mem_req_valid asserts the cycle after the req handshake.
  - resp_valid asserts the cycle after the final mem_resp_valid.
  - Response fields are registered and stable while resp_valid=1 and resp_ready=0.
- mem_req_valid and addr are held stable until mem_req_ready.
- mem_resp_valid outside WAIT is ignored.
- Simultaneous resp handshake and new req_valid: the new request is not accepted in the same cycle; req_ready is high only in IDLE.
- Reset (reset=0) at any state:
  - next state IDLE;
  - all outputs 0 except req_ready=1;
  - internal registers cleared;
  - responses for in-flight reads arriving after reset are ignored.

Optional Feature:
- Macro: PTW_AD_CHECK_EN.
- Defined: a leaf with a=0 raises pf=1 at that level.
- Undefined: the a bit is passed through unchecked and no A-bit fault is raised.

Decomposition:
- Package ptw_pkg holds:
  - PTE bit-offset constants (PPN_LSB=10, PPN_MSB=53, RSVD_LSB=54);
  - flag index constants;
  - state enum typedef (IDLE, REQ, WAIT, RESP);
  - LEVELS.
- Sub-module ptw_pte_decode: combinational. Inputs data and level; outputs ppn, flags, leaf, invalid, misaligned.

Test Plan:
- 3-level walk, satp_ppn=0x80000, vpn=0x0000001. Memory returns 0x20000401 (at 0x80000000), 0x20000801 (at 0x80001000), 0x48D14CF (at 0x80002008). Required: three mem_req addresses exactly as listed; resp ppn=0x12345, d=a=x=w=r=v=1, g=u=0, level=0, pf=0.
- Invalid root PTE: data=0 at 0x80000000 -> single mem access, resp pf=1, level=2.
- Superpage at level 1, vpn=1:
  - L2 PTE 0x20000401; L1 data 0x200800CF (ppn 0x80200) -> resp ppn=0x80201, level=1, pf=0;
  - L1 data 0x200804CF (ppn 0x80201, misaligned) -> pf=1, level=1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. Required: outputs stable, req_ready=0. Hold mem_req_ready=0 for 3 cycles: addr stable.
- Reset during WAIT, then a stale mem_resp_valid pulse. Required: busy=0 and mem_req_valid=0 the cycle after reset; stale pulse ignored; a subsequent walk matches test 1.
- Leaf flags 0x0F (a=0) at level 0. Required: pf=1 with PTW_AD_CHECK_EN; pf=0 and a=0 passed through without it.
